// File: rtl/systolic_column_accumulator_if.sv
// Partial-sum input stream, configuration and result handshake for one column accumulator.
interface systolic_column_accumulator_if #(
  parameter int unsigned FIXED_POINT_WIDTH    = 16,
  parameter int unsigned PARTIAL_SUM_WIDTH_IN = 17,
  parameter int unsigned TILE_COUNT_WIDTH     = 8
);
  logic                            start_in;
  logic [TILE_COUNT_WIDTH-1:0]     tile_count_in;
  logic [FIXED_POINT_WIDTH-1:0]    bias_in;
  logic [PARTIAL_SUM_WIDTH_IN-1:0] partial_sum_in;
  logic                            partial_sum_valid_in;
  logic                            partial_sum_ready_out;
  logic [FIXED_POINT_WIDTH-1:0]    result_out;
  logic                            result_valid_out;
  logic                            result_ready_in;
  logic                            overflow_out;
  logic                            busy_out;

  modport master (
    output start_in, tile_count_in, bias_in, partial_sum_in, partial_sum_valid_in, result_ready_in,
    input  partial_sum_ready_out, result_out, result_valid_out, overflow_out, busy_out
  );

  modport slave (
    input  start_in, tile_count_in, bias_in, partial_sum_in, partial_sum_valid_in, result_ready_in,
    output partial_sum_ready_out, result_out, result_valid_out, overflow_out, busy_out
  );
endinterface

// File: rtl/systolic_column_accumulator.sv
// Accumulates K-tile partial sums of one systolic column onto a bias and emits a saturated Q result.
// Optional output ReLU enabled by defining SYSTOLIC_COLUMN_ACCUMULATOR_RELU_EN.
module systolic_column_accumulator #(
  parameter int unsigned FIXED_POINT_WIDTH    = 16,
  parameter int unsigned FIXED_POINT_POSITION = 10,
  parameter int unsigned PARTIAL_SUM_WIDTH_IN = 17,
  parameter int unsigned ACCUM_WIDTH          = 28,
  parameter int unsigned TILE_COUNT_WIDTH     = 8
) (
  input logic                          clk_in,
  input logic                          rst_in,
  systolic_column_accumulator_if.slave bus
);
  localparam int unsigned SEXT_PS  = ACCUM_WIDTH - PARTIAL_SUM_WIDTH_IN;
  localparam int unsigned SEXT_B   = ACCUM_WIDTH - FIXED_POINT_WIDTH;
  localparam int unsigned CNT_W    = TILE_COUNT_WIDTH + 1;
  localparam logic signed [ACCUM_WIDTH-1:0] SAT_MAX = {{(SEXT_B+1){1'b0}}, {(FIXED_POINT_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH-1:0] SAT_MIN = {{(SEXT_B+1){1'b1}}, {(FIXED_POINT_WIDTH-1){1'b0}}};

  if (ACCUM_WIDTH < PARTIAL_SUM_WIDTH_IN + TILE_COUNT_WIDTH + 1 || ACCUM_WIDTH <= FIXED_POINT_WIDTH) begin : g_bad_accum
    $error("ACCUM_WIDTH too narrow to accumulate without wrap");
  end
  if (FIXED_POINT_POSITION >= FIXED_POINT_WIDTH) begin : g_bad_fraction
    $error("FIXED_POINT_POSITION must be below FIXED_POINT_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                         state_q;
  logic signed [ACCUM_WIDTH-1:0]  acc_q;
  logic [TILE_COUNT_WIDTH-1:0]    count_q;
  logic [TILE_COUNT_WIDTH-1:0]    limit_q;
  logic [FIXED_POINT_WIDTH-1:0]   result_q;
  logic                           result_valid_q;
  logic                           overflow_q;
  logic                           psum_ready_q;
  logic                           busy_q;

  logic signed [ACCUM_WIDTH-1:0]  psum_ext_c;
  logic signed [ACCUM_WIDTH-1:0]  bias_ext_c;
  logic signed [ACCUM_WIDTH-1:0]  acc_sum_c;
  logic [TILE_COUNT_WIDTH-1:0]    limit_c;
  logic [FIXED_POINT_WIDTH-1:0]   sat_c;
  logic [FIXED_POINT_WIDTH-1:0]   final_c;
  logic                           sat_hit_c;
  logic                           last_beat_c;
  logic                           load_c;

  // Datapath: extension, running sum, single output saturation stage.
  always_comb begin
    psum_ext_c  = {{SEXT_PS{bus.partial_sum_in[PARTIAL_SUM_WIDTH_IN-1]}}, bus.partial_sum_in};
    bias_ext_c  = {{SEXT_B{bus.bias_in[FIXED_POINT_WIDTH-1]}}, bus.bias_in};
    acc_sum_c   = acc_q + psum_ext_c;
    limit_c     = (bus.tile_count_in == '0) ? TILE_COUNT_WIDTH'(1) : bus.tile_count_in;
    last_beat_c = ({1'b0, count_q} + CNT_W'(1)) == {1'b0, limit_q};
    sat_hit_c   = 1'b0;
    sat_c       = acc_sum_c[FIXED_POINT_WIDTH-1:0];
    if (acc_sum_c > SAT_MAX) begin
      sat_c     = {1'b0, {(FIXED_POINT_WIDTH-1){1'b1}}};
      sat_hit_c = 1'b1;
    end else if (acc_sum_c < SAT_MIN) begin
      sat_c     = {1'b1, {(FIXED_POINT_WIDTH-1){1'b0}}};
      sat_hit_c = 1'b1;
    end
`ifdef SYSTOLIC_COLUMN_ACCUMULATOR_RELU_EN
    final_c = sat_c[FIXED_POINT_WIDTH-1] ? '0 : sat_c;
`else
    final_c = sat_c;
`endif
    // A start is taken from IDLE, or from OUTPUT only when the result is handed off that cycle.
    load_c = bus.start_in && ((state_q == IDLE) || ((state_q == OUTPUT) && bus.result_ready_in));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      count_q        <= '0;
      limit_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      psum_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else if (load_c) begin
      acc_q          <= bias_ext_c;
      limit_q        <= limit_c;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
      psum_ready_q   <= 1'b1;
      busy_q         <= 1'b1;
      state_q        <= ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.partial_sum_valid_in) begin
            acc_q   <= acc_sum_c;
            count_q <= count_q + TILE_COUNT_WIDTH'(1);
            if (last_beat_c) begin
              result_q       <= final_c;
              overflow_q     <= sat_hit_c;
              result_valid_q <= 1'b1;
              psum_ready_q   <= 1'b0;
              state_q        <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (bus.result_ready_in) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result_out            = result_q;
  assign bus.result_valid_out      = result_valid_q;
  assign bus.overflow_out          = overflow_q;
  assign bus.partial_sum_ready_out = psum_ready_q;
  assign bus.busy_out              = busy_q;
endmodule
